// File: rtl/mmio_arb.sv
// Round-robin arbiter sharing ctrlr's byte-wide MMIO port among N_REQ requesters, grant locked for a 2-byte frame.
// Optional macro MMIO_ARB_TIMEOUT_EN: finish an abandoned frame with a dummy 8'h00 byte after TIMEOUT cycles in WAIT2.
module mmio_arb #(
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_byte,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   rsp_valid,
   output logic [7:0]         rsp_byte,
   output logic               busy,
   output logic [1:0]         owner,
   output logic               timeout_err,
   output logic               new_data,
   output logic [7:0]         din,
   input  logic [7:0]         dout
);

   // Handshake: a requester holds req_valid/req_byte until it sees its 1-cycle req_ready pulse;
   // rsp_valid is a 1-cycle pulse with no back-pressure.
   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, WAIT2} state_t;

   state_t           state;
   logic [1:0]       rr_ptr;
   logic             byte_idx;

   logic [3:0]       valid4;
   logic [31:0]      bytes4;
   logic [2:0]       cand;
   logic             grant_found;
   logic [1:0]       grant_idx;
   logic [N_REQ-1:0] grant_sel;
   logic [N_REQ-1:0] owner_sel;
   logic [7:0]       grant_byte;
   logic [7:0]       owner_byte;
   logic [1:0]       next_ptr;

   assign busy = (state != IDLE);

   // Lanes padded to 4 so a 2-bit index is always in range.
   always_comb begin
      valid4 = 4'(req_valid);
      bytes4 = 32'(req_byte);
   end

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = rr_ptr;
      cand        = 3'd0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, rr_ptr} + 3'(k);
         if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
         if (!grant_found && valid4[cand[1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[1:0];
         end
      end
   end

   always_comb begin
      grant_sel = '0;
      owner_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         grant_sel[i] = (grant_idx == 2'(i));
         owner_sel[i] = (owner == 2'(i));
      end
   end

   always_comb begin
      grant_byte = bytes4[{grant_idx, 3'b000} +: 8];
      owner_byte = bytes4[{owner, 3'b000} +: 8];
      next_ptr   = (owner == 2'(N_REQ - 1)) ? 2'd0 : owner + 2'd1;
   end

`ifdef MMIO_ARB_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic       dummy;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= 2'd0;
         byte_idx  <= 1'b0;
         new_data  <= 1'b0;
         din       <= 8'h00;
         req_ready <= '0;
         rsp_valid <= '0;
         rsp_byte  <= 8'h00;
         owner     <= 2'd0;
`ifdef MMIO_ARB_TIMEOUT_EN
         timeout_err <= 1'b0;
         wait_cnt    <= 8'd0;
         dummy       <= 1'b0;
`endif
      end else begin
         new_data  <= 1'b0;
         req_ready <= '0;
         rsp_valid <= '0;
`ifdef MMIO_ARB_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (grant_found) begin
                  din       <= grant_byte;
                  new_data  <= 1'b1;
                  req_ready <= grant_sel;
                  owner     <= grant_idx;
                  byte_idx  <= 1'b0;
                  state     <= ISSUE;
`ifdef MMIO_ARB_TIMEOUT_EN
                  dummy     <= 1'b0;
`endif
               end
            end
            ISSUE: state <= CAPT;
            CAPT: begin
`ifdef MMIO_ARB_TIMEOUT_EN
               if (dummy) begin
                  timeout_err <= 1'b1;
               end else begin
                  rsp_byte  <= dout;
                  rsp_valid <= owner_sel;
               end
               wait_cnt <= 8'd0;
`else
               rsp_byte  <= dout;
               rsp_valid <= owner_sel;
`endif
               if (byte_idx) begin
                  state  <= IDLE;
                  rr_ptr <= next_ptr;
               end else begin
                  state  <= WAIT2;
               end
            end
            WAIT2: begin
               // Only the owner may supply the second byte; others stay pending.
               if (valid4[owner]) begin
                  din       <= owner_byte;
                  new_data  <= 1'b1;
                  req_ready <= owner_sel;
                  byte_idx  <= 1'b1;
                  state     <= ISSUE;
               end
`ifdef MMIO_ARB_TIMEOUT_EN
               else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                  din      <= 8'h00;
                  new_data <= 1'b1;
                  byte_idx <= 1'b1;
                  dummy    <= 1'b1;
                  state    <= ISSUE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef MMIO_ARB_TIMEOUT_EN
   assign timeout_err = 1'b0;
`endif

endmodule
